pulse_pacer: RTL and testbench
==============================

// Module: pulse_pacer
// PURPOSE
//  Source-domain stage placed directly ahead of the single-pulse clock-domain synchronizer.
//  The synchronizer accepts only one-cycle pulses, spaced widely enough for the destination clock to see each toggle.
//  This block accepts arbitrary event requests and counts the pending ones.
//  It re-issues them as one-cycle pulses with a guaranteed minimum spacing, and flags lost events.
// PARAMETERS
//  SPACING  4  min clk cycles between successive pulse_out assertions, start to start; legal >=2
//  CNT_W    4  width of pending-event counter; max pending = 2**CNT_W-1
//  EDGE     1  1: each rising edge of req is one event; 0: each clk cycle with req high is one event
// PORTS
//  clk       in   1      source-domain clock; single clock, all logic on posedge
//  rst_n     in   1      asynchronous, active-low reset
//  req       in   1      event request (edge or level per EDGE)
//  flush     in   1      sync clear of pending count
//  clr_ovf   in   1      sync clear of overflow flag
//  pulse_out out  1      one-cycle paced pulse; drives synchronizer input
//  pending   out  CNT_W  events accepted but not yet issued
//  overflow  out  1      sticky: an event was dropped at saturation
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pulse_out=0, pending=0, overflow=0, state=IDLE, gap_cnt=0.
//   - req_d=1, so req already high at reset release is not an edge event.
//  Event detect:
//   - ev = EDGE ? (req & ~req_d) : req
//   - req_d <= req every cycle.
//  States: IDLE, GAP.
//   - issue = (state==IDLE) & (pending!=0).
//   - IDLE: on issue -> GAP, gap_cnt <= SPACING-1; otherwise stay in IDLE.
//   - GAP: gap_cnt decrements each cycle; when gap_cnt==1 -> IDLE next cycle.
//  Output:
//   - pulse_out <= issue (registered), so it is never high two cycles in a row.
//   - Successive pulses are >= SPACING cycles apart; exactly SPACING apart when backlogged.
//  Pending counter: pending_next = pending + ev - issue.
//   - ev & issue in the same cycle: pending unchanged.
//   - ev at pending==max with no issue: pending stays max, event dropped, overflow<=1.
//   - issue uses the registered pending, so an event arriving in IDLE with pending==0 is not bypassed.
//  Latency:
//   - ev in cycle N -> pending=1 in cycle N+1 -> pulse_out high in cycle N+2, when idle.
//  flush:
//   - pending<=0; any ev in the same cycle is discarded.
//   - A pulse already registered and the running gap are not aborted; the state machine completes GAP normally.
//   - flush does not set overflow.
//  clr_ovf: overflow<=0; if a drop occurs in the same cycle, set wins (overflow=1).
//  Reset mid-GAP or with pending>0: everything returns to reset values immediately; no residual pulse.
//  Widths: gap_cnt is clog2(SPACING) bits; pending arithmetic saturates and never wraps.
// TESTING
//  1. SPACING=4, EDGE=1; single rising edge of req at cycle 10 -> pulse_out=1 only in cycle 12; pending 1 in cycle 11, 0 in 12.
//  2. EDGE=0; req high cycles 10-12 -> pulses in cycles 12, 16, 20; pending peaks at 2; overflow stays 0.
//  3. CNT_W=2, EDGE=0; req high cycles 10-16 -> exactly 5 pulses total; overflow=1 from the first drop; clr_ovf pulse clears it.
//  4. SPACING=2; ev and issue in the same cycle -> pending unchanged; pulses exactly 2 cycles apart; pulse_out never high 2 consecutive cycles.
//  5. pending=3 mid-GAP, flush with simultaneous req edge -> pending=0, no further pulses, GAP ends on schedule, overflow unchanged.
//  6. rst_n low mid-GAP with pending=2, req held high through release (EDGE=1) -> all outputs 0; no pulse after release until a new rising edge.

Source files
------------

// File: rtl/pulse_pacer_if.sv
// Request/flush inputs and paced-pulse status outputs of pulse_pacer.
// master = the logic producing events, slave = the pacer.
interface pulse_pacer_if #(
    parameter int CNT_W = 4
);
    logic             req;
    logic             flush;
    logic             clr_ovf;
    logic             pulse_out;
    logic [CNT_W-1:0] pending;
    logic             overflow;

    modport master (
        output req,
        output flush,
        output clr_ovf,
        input  pulse_out,
        input  pending,
        input  overflow
    );

    modport slave (
        input  req,
        input  flush,
        input  clr_ovf,
        output pulse_out,
        output pending,
        output overflow
    );
endinterface

// File: rtl/pulse_pacer.sv
// Counts event requests and re-issues them as single-cycle pulses spaced at least
// SPACING cycles apart, ahead of a single-pulse clock-domain synchronizer.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_IDLE | free to issue; a pulse is issued whenever pending is non-zero
//  ST_GAP  | enforcing spacing after an issue; gap counter runs down to 1
module pulse_pacer #(
    parameter int SPACING = 4,
    parameter int CNT_W   = 4,
    parameter int EDGE    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    pulse_pacer_if.slave bus
);
    localparam int               GAP_W    = (SPACING > 2) ? $clog2(SPACING) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SPACING - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(1);
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;

    logic [0:0]       r_state;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_req_d;
    logic             r_pulse;
    logic [CNT_W-1:0] r_pending;
    logic             r_overflow;

    logic w_ev;
    logic w_issue;
    logic w_inc;
    logic w_dec;
    logic w_sat;
    logic w_drop;

    // r_req_d resets high so a req already asserted at reset release is not an edge
    assign w_ev    = (EDGE != 0) ? (bus.req & ~r_req_d) : bus.req;
    assign w_issue = (r_state == ST_IDLE) && (r_pending != '0);
    assign w_inc   = w_ev & ~w_issue;
    assign w_dec   = w_issue & ~w_ev;
    assign w_sat   = (r_pending == PEND_MAX);
    assign w_drop  = w_inc & w_sat & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_d <= 1'b1;
        end else begin
            r_req_d <= bus.req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt - GAP_LAST;
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_gap_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_issue;
        end
    end

    // flush wins over a same-cycle event; the running gap is left to finish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (bus.flush) begin
            r_pending <= '0;
        end else if (w_inc && !w_sat) begin
            r_pending <= r_pending + 1'b1;
        end else if (w_dec) begin
            r_pending <= r_pending - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.pulse_out = r_pulse;
    assign bus.pending   = r_pending;
    assign bus.overflow  = r_overflow;

    a_no_consecutive_pulse: assert property (
        @(posedge clk) disable iff (!rst_n) r_pulse |=> !r_pulse
    );

endmodule

// File: tb/tb_pulse_pacer.sv
// Bench for pulse_pacer: three parameterisations share one stimulus stream and are
// compared against a cycle-level reference built from count/time arithmetic.
module tb_pulse_pacer;
    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic req     = 1'b0;
    logic flush   = 1'b0;
    logic clr_ovf = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pulse_pacer_if #(.CNT_W(4)) if_a ();
    pulse_pacer_if #(.CNT_W(2)) if_b ();
    pulse_pacer_if #(.CNT_W(4)) if_c ();

    assign if_a.req = req;  assign if_a.flush = flush;  assign if_a.clr_ovf = clr_ovf;
    assign if_b.req = req;  assign if_b.flush = flush;  assign if_b.clr_ovf = clr_ovf;
    assign if_c.req = req;  assign if_c.flush = flush;  assign if_c.clr_ovf = clr_ovf;

    // instance 0: SPACING 4, 4-bit count, edge events
    pulse_pacer #(.SPACING(4), .CNT_W(4), .EDGE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    // instance 1: SPACING 4, 2-bit count, level events
    pulse_pacer #(.SPACING(4), .CNT_W(2), .EDGE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    // instance 2: SPACING 2, 4-bit count, level events
    pulse_pacer #(.SPACING(2), .CNT_W(4), .EDGE(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    logic       d_pulse [3];
    logic [3:0] d_pend  [3];
    logic       d_ovf   [3];

    always_comb begin
        d_pulse[0] = if_a.pulse_out;
        d_pulse[1] = if_b.pulse_out;
        d_pulse[2] = if_c.pulse_out;
        d_pend[0]  = if_a.pending;
        d_pend[1]  = {2'b00, if_b.pending};
        d_pend[2]  = if_c.pending;
        d_ovf[0]   = if_a.overflow;
        d_ovf[1]   = if_b.overflow;
        d_ovf[2]   = if_c.overflow;
    end

    function automatic int sp_of(int k);
        return (k == 2) ? 2 : 4;
    endfunction
    function automatic int max_of(int k);
        return (k == 1) ? 3 : 15;
    endfunction
    function automatic bit edge_of(int k);
        return (k == 0);
    endfunction

    // Reference: a pulse may start at cycle t when something is pending and
    // t is at least SPACING past the previous start.
    int m_pend  [3] = '{0, 0, 0};
    bit m_ovf   [3] = '{0, 0, 0};
    bit m_pulse [3] = '{0, 0, 0};
    bit m_req_d [3] = '{1, 1, 1};
    int m_last  [3] = '{-1000, -1000, -1000};
    int m_cyc = 0;
    bit mv_ev, mv_iss;
    int mv_nxt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_pend[k]  = 0;
                m_ovf[k]   = 0;
                m_pulse[k] = 0;
                m_req_d[k] = 1;
                m_last[k]  = -1000;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                mv_ev  = edge_of(k) ? (req && !m_req_d[k]) : req;
                mv_iss = (m_pend[k] > 0) && (m_cyc >= m_last[k] + sp_of(k));
                m_pulse[k] = mv_iss;
                if (mv_iss) m_last[k] = m_cyc;
                mv_nxt = m_pend[k] + int'(mv_ev) - int'(mv_iss);
                if (flush) begin
                    m_pend[k] = 0;
                    if (clr_ovf) m_ovf[k] = 0;
                end else if (mv_nxt > max_of(k)) begin
                    m_pend[k] = max_of(k);
                    m_ovf[k]  = 1;
                end else begin
                    m_pend[k] = mv_nxt;
                    if (clr_ovf) m_ovf[k] = 0;
                end
                m_req_d[k] = req;
            end
            m_cyc++;
        end
    end

    task automatic drain(input int n);
        req = 0; flush = 0; clr_ovf = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (d_pulse[k] !== 1'b0) begin n_err++; $display("FAIL reset_pulse inst=%0d got=%0b exp=0", k, d_pulse[k]); end
            n_chk++; if (d_pend[k] !== 4'd0) begin n_err++; $display("FAIL reset_pend inst=%0d got=%0d exp=0", k, d_pend[k]); end
            n_chk++; if (d_ovf[k] !== 1'b0) begin n_err++; $display("FAIL reset_ovf inst=%0d got=%0b exp=0", k, d_ovf[k]); end
        end
        rst_n = 1;
        repeat (4) @(negedge clk);
        n_chk++; if (d_pulse[0] !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got=%0b exp=0", d_pulse[0]); end
    endtask

    task automatic test_single_edge();
        drain(40);
        req = 1;
        @(negedge clk);
        n_chk++; if (d_pend[0] !== 4'd1) begin n_err++; $display("FAIL edge_pend_n1 got=%0d exp=1", d_pend[0]); end
        n_chk++; if (d_pulse[0] !== 1'b0) begin n_err++; $display("FAIL edge_pulse_n1 got=%0b exp=0", d_pulse[0]); end
        req = 0;
        @(negedge clk);
        n_chk++; if (d_pulse[0] !== 1'b1) begin n_err++; $display("FAIL edge_pulse_n2 got=%0b exp=1", d_pulse[0]); end
        n_chk++; if (d_pend[0] !== 4'd0) begin n_err++; $display("FAIL edge_pend_n2 got=%0d exp=0", d_pend[0]); end
        @(negedge clk);
        n_chk++; if (d_pulse[0] !== 1'b0) begin n_err++; $display("FAIL edge_pulse_n3 got=%0b exp=0", d_pulse[0]); end
    endtask

    task automatic test_level_burst();
        int q[$];
        int exp_t[3] = '{2, 6, 10};
        int peak = 0;
        drain(40);
        req = 1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (d_pulse[1] === 1'b1) q.push_back(i);
            if (int'(d_pend[1]) > peak) peak = int'(d_pend[1]);
            n_chk++; if (d_ovf[1] !== 1'b0) begin n_err++; $display("FAIL burst_ovf t=%0d got=%0b exp=0", i, d_ovf[1]); end
            req = (i < 3);
        end
        n_chk++; if (q.size() != 3) begin n_err++; $display("FAIL burst_npulses got=%0d exp=3", q.size()); end
        for (int j = 0; j < 3 && j < q.size(); j++) begin
            n_chk++; if (q[j] != exp_t[j]) begin n_err++; $display("FAIL burst_time[%0d] got=%0d exp=%0d", j, q[j], exp_t[j]); end
        end
        n_chk++; if (peak != 2) begin n_err++; $display("FAIL burst_peak got=%0d exp=2", peak); end
    endtask

    task automatic test_saturate();
        int cnt = 0;
        drain(40);
        clr_ovf = 1;
        @(negedge clk);
        clr_ovf = 0;
        req = 1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (d_pulse[1] === 1'b1) cnt++;
            if (i == 4) begin
                n_chk++; if (d_ovf[1] !== 1'b0) begin n_err++; $display("FAIL sat_ovf_before got=%0b exp=0", d_ovf[1]); end
            end
            if (i >= 5) begin
                n_chk++; if (d_ovf[1] !== 1'b1) begin n_err++; $display("FAIL sat_ovf_sticky t=%0d got=%0b exp=1", i, d_ovf[1]); end
            end
            req = (i < 7);
        end
        n_chk++; if (cnt != 5) begin n_err++; $display("FAIL sat_npulses got=%0d exp=5", cnt); end
        clr_ovf = 1;
        @(negedge clk);
        clr_ovf = 0;
        n_chk++; if (d_ovf[1] !== 1'b0) begin n_err++; $display("FAIL sat_clr_ovf got=%0b exp=0", d_ovf[1]); end
    endtask

    task automatic test_back_to_back();
        logic prev = 1'b0;
        drain(40);
        req = 1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n_chk++; if (d_pulse[2] !== ((i >= 2) && (i % 2 == 0))) begin n_err++; $display("FAIL b2b_pulse t=%0d got=%0b exp=%0b", i, d_pulse[2], ((i >= 2) && (i % 2 == 0))); end
            n_chk++; if (int'(d_pend[2]) != (i + 1) / 2) begin n_err++; $display("FAIL b2b_pend t=%0d got=%0d exp=%0d", i, d_pend[2], (i + 1) / 2); end
            n_chk++; if (prev === 1'b1 && d_pulse[2] === 1'b1) begin n_err++; $display("FAIL b2b_consecutive t=%0d got=1 exp=0", i); end
            prev = d_pulse[2];
        end
        req = 0;
    endtask

    task automatic test_flush_mid_gap();
        bit found = 0;
        bit ovf_exp;
        drain(40);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_chk++; if (d_pend[k] !== 4'(m_pend[k])) begin n_err++; $display("FAIL flush_pre_pend inst=%0d got=%0d exp=%0d", k, d_pend[k], m_pend[k]); end
                n_chk++; if (d_pulse[k] !== m_pulse[k]) begin n_err++; $display("FAIL flush_pre_pulse inst=%0d got=%0b exp=%0b", k, d_pulse[k], m_pulse[k]); end
            end
            if (m_pend[0] == 3 && m_cyc > m_last[0] && m_cyc < m_last[0] + 4 && req == 1'b0) begin
                req = 1; flush = 1; found = 1;
                break;
            end
            req = ~req;
        end
        n_chk++; if (!found) begin n_err++; $display("FAIL flush_setup got=timeout exp=pending3_in_gap"); end
        if (found) begin
            ovf_exp = m_ovf[0];
            @(negedge clk);
            flush = 0; req = 0;
            n_chk++; if (d_pend[0] !== 4'd0) begin n_err++; $display("FAIL flush_pend got=%0d exp=0", d_pend[0]); end
            for (int j = 1; j <= 12; j++) begin
                @(negedge clk);
                n_chk++; if (d_pulse[0] !== 1'b0) begin n_err++; $display("FAIL flush_no_pulse t=%0d got=%0b exp=0", j, d_pulse[0]); end
                n_chk++; if (d_pend[0] !== 4'd0) begin n_err++; $display("FAIL flush_pend_hold t=%0d got=%0d exp=0", j, d_pend[0]); end
                n_chk++; if (d_ovf[0] !== ovf_exp) begin n_err++; $display("FAIL flush_ovf t=%0d got=%0b exp=%0b", j, d_ovf[0], ovf_exp); end
            end
        end
    endtask

    task automatic test_reset_mid_gap();
        bit found = 0;
        drain(40);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_pend[0] == 2 && m_cyc > m_last[0] && m_cyc < m_last[0] + 4 && req == 1'b1) begin
                found = 1;
                break;
            end
            req = ~req;
        end
        n_chk++; if (!found) begin n_err++; $display("FAIL rstgap_setup got=timeout exp=pending2_in_gap"); end
        #2 rst_n = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (d_pulse[k] !== 1'b0) begin n_err++; $display("FAIL rstgap_pulse inst=%0d got=%0b exp=0", k, d_pulse[k]); end
            n_chk++; if (d_pend[k] !== 4'd0) begin n_err++; $display("FAIL rstgap_pend inst=%0d got=%0d exp=0", k, d_pend[k]); end
            n_chk++; if (d_ovf[k] !== 1'b0) begin n_err++; $display("FAIL rstgap_ovf inst=%0d got=%0b exp=0", k, d_ovf[k]); end
        end
        repeat (3) @(negedge clk);
        rst_n = 1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            n_chk++; if (d_pulse[0] !== 1'b0) begin n_err++; $display("FAIL rstgap_no_pulse t=%0d got=%0b exp=0", j, d_pulse[0]); end
            n_chk++; if (d_pend[0] !== 4'd0) begin n_err++; $display("FAIL rstgap_no_pend t=%0d got=%0d exp=0", j, d_pend[0]); end
            for (int k = 1; k < 3; k++) begin
                n_chk++; if (d_pend[k] !== 4'(m_pend[k])) begin n_err++; $display("FAIL rstgap_lvl_pend inst=%0d got=%0d exp=%0d", k, d_pend[k], m_pend[k]); end
            end
        end
        req = 0;
        @(negedge clk);
        req = 1;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (d_pulse[0] !== 1'b1) begin n_err++; $display("FAIL rstgap_new_edge got=%0b exp=1", d_pulse[0]); end
    endtask

    task automatic test_random();
        int thr;
        drain(40);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_chk++; if (d_pulse[k] !== m_pulse[k]) begin n_err++; $display("FAIL rand_pulse inst=%0d t=%0d got=%0b exp=%0b", k, i, d_pulse[k], m_pulse[k]); end
                n_chk++; if (d_pend[k] !== 4'(m_pend[k])) begin n_err++; $display("FAIL rand_pend inst=%0d t=%0d got=%0d exp=%0d", k, i, d_pend[k], m_pend[k]); end
                n_chk++; if (d_ovf[k] !== m_ovf[k]) begin n_err++; $display("FAIL rand_ovf inst=%0d t=%0d got=%0b exp=%0b", k, i, d_ovf[k], m_ovf[k]); end
            end
            thr     = (i < 150) ? 80 : ((i < 300) ? 30 : 60);
            req     = ($urandom_range(99) < thr);
            flush   = ($urandom_range(99) < 3);
            clr_ovf = ($urandom_range(99) < 5);
        end
        drain(1);
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_level_burst();
        test_saturate();
        test_back_to_back();
        test_flush_mid_gap();
        test_reset_mid_gap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
